// File: rtl/wb_write_arbiter.sv
// Register-file write port: round-robin arbiter over ALU/MEM/MDU results,
// registered single write port, and a pending-write scoreboard for RAW stalls.
module wb_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_iss_valid,
    input  logic [ADDR_W-1:0] i_iss_waddr,
    input  logic              i_alu_valid,
    input  logic              i_mem_valid,
    input  logic              i_mdu_valid,
    input  logic [ADDR_W-1:0] i_alu_waddr,
    input  logic [ADDR_W-1:0] i_mem_waddr,
    input  logic [ADDR_W-1:0] i_mdu_waddr,
    input  logic [DATA_W-1:0] i_alu_wdata,
    input  logic [DATA_W-1:0] i_mem_wdata,
    input  logic [DATA_W-1:0] i_mdu_wdata,
    output logic              o_alu_ready,
    output logic              o_mem_ready,
    output logic              o_mdu_ready,
    input  logic [ADDR_W-1:0] i_rs_addr,
    input  logic [ADDR_W-1:0] i_rt_addr,
    output logic              o_rs_busy,
    output logic              o_rt_busy,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [DATA_W-1:0] o_wdata,
    output logic [ADDR_W:0]   o_pending_cnt,
    output logic              o_err
);
    localparam int NREG = 2**ADDR_W;
    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MEM = 2'd1;
    localparam logic [1:0] SRC_MDU = 2'd2;

    logic [1:0]        rr_q, rr_d;
    logic [2:0]        req, gnt;
    logic              gnt_any;
    logic [1:0]        gnt_src;
    logic [ADDR_W-1:0] gnt_waddr;
    logic [DATA_W-1:0] gnt_wdata;

    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NREG-1:0]   busy_q, busy_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              set_hit;

    assign req = {i_mdu_valid, i_mem_valid, i_alu_valid};

    // Search begins at the source after the last grant (ALU -> MEM -> MDU cyclic).
    always_comb begin
        gnt = 3'b000;
        case (rr_q)
            SRC_ALU: gnt = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
            SRC_MEM: gnt = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
            default: gnt = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
        endcase
        if (!i_rst_n) begin
            gnt = 3'b000;
        end
    end

    always_comb begin
        gnt_any   = |gnt;
        gnt_src   = rr_q;
        gnt_waddr = i_alu_waddr;
        gnt_wdata = i_alu_wdata;
        if (gnt[1]) begin
            gnt_src   = SRC_MEM;
            gnt_waddr = i_mem_waddr;
            gnt_wdata = i_mem_wdata;
        end else if (gnt[2]) begin
            gnt_src   = SRC_MDU;
            gnt_waddr = i_mdu_waddr;
            gnt_wdata = i_mdu_wdata;
        end else if (gnt[0]) begin
            gnt_src   = SRC_ALU;
        end
        rr_d = gnt_any ? gnt_src : rr_q;
    end

    assign o_alu_ready = gnt[0];
    assign o_mem_ready = gnt[1];
    assign o_mdu_ready = gnt[2];

    // Set is applied after clear so a same-edge reissue keeps the register busy.
    always_comb begin
        busy_d  = busy_q;
        err_d   = err_q;
        set_hit = i_iss_valid && (i_iss_waddr != '0);
        if (set_hit && busy_q[i_iss_waddr] && !(we_q && (waddr_q == i_iss_waddr))) begin
            err_d = 1'b1;
        end
        if (gnt_any && (gnt_waddr != '0) && !busy_q[gnt_waddr]) begin
            err_d = 1'b1;
        end
        if (we_q) begin
            busy_d[waddr_q] = 1'b0;
        end
        if (set_hit) begin
            busy_d[i_iss_waddr] = 1'b1;
        end
        cnt_d = '0;
        for (int i = 1; i < NREG; i++) begin
            cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rr_q    <= SRC_MDU;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            rr_q   <= rr_d;
            we_q   <= gnt_any && (gnt_waddr != '0);
            if (gnt_any) begin
                waddr_q <= gnt_waddr;
                wdata_q <= gnt_wdata;
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // A write already in flight when reset arrives must not reach the register file.
    assign o_we          = we_q & i_rst_n;
    assign o_waddr       = waddr_q;
    assign o_wdata       = wdata_q;
    assign o_pending_cnt = cnt_q;
    assign o_err         = err_q;
    assign o_rs_busy     = (i_rs_addr != '0) && busy_q[i_rs_addr];
    assign o_rt_busy     = (i_rt_addr != '0) && busy_q[i_rt_addr];

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a queue/array reference model.
module tb_wb_write_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_v;
    logic [4:0]  iss_a, rs, rt;
    logic        pv [3];
    logic [4:0]  pa [3];
    logic [31:0] pd [3];
    logic        alu_rdy, mem_rdy, mdu_rdy, rs_busy, rt_busy, we, err;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [5:0]  pend;

    always #5 clk = ~clk;

    wb_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_iss_valid(iss_v), .i_iss_waddr(iss_a),
        .i_alu_valid(pv[0]), .i_mem_valid(pv[1]), .i_mdu_valid(pv[2]),
        .i_alu_waddr(pa[0]), .i_mem_waddr(pa[1]), .i_mdu_waddr(pa[2]),
        .i_alu_wdata(pd[0]), .i_mem_wdata(pd[1]), .i_mdu_wdata(pd[2]),
        .o_alu_ready(alu_rdy), .o_mem_ready(mem_rdy), .o_mdu_ready(mdu_rdy),
        .i_rs_addr(rs), .i_rt_addr(rt),
        .o_rs_busy(rs_busy), .o_rt_busy(rt_busy),
        .o_we(we), .o_waddr(waddr), .o_wdata(wdata),
        .o_pending_cnt(pend), .o_err(err)
    );

    int n_total = 0;
    int n_bad   = 0;

    // reference model
    bit          m_busy [32];
    bit          m_err;
    int          m_last;
    bit          m_we;
    int          m_waddr;
    logic [31:0] m_wdata;
    int          m_gnt;
    int          cyc = 0;
    int          wlog [$];
    int          wcyc [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_err = 1'b0; m_last = 2; m_we = 1'b0; m_waddr = 0; m_wdata = '0;
    endtask

    task automatic step();
        int g;
        int cnt;
        logic [2:0] exp_rdy;
        bit set_hit;
        @(negedge clk);
        g = -1;
        if (rst_n) begin
            for (int k = 1; k <= 3; k++) begin
                int s;
                s = (m_last + k) % 3;
                if (g < 0 && pv[s]) g = s;
            end
        end
        exp_rdy = 3'b000;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("ready", {mdu_rdy, mem_rdy, alu_rdy}, exp_rdy);
        chk("rs_busy", rs_busy, (rs != 0) && m_busy[rs]);
        chk("rt_busy", rt_busy, (rt != 0) && m_busy[rt]);
        chk("we", we, m_we && rst_n);
        if (m_we && rst_n) begin
            chk("waddr", waddr, m_waddr);
            chk("wdata", wdata, m_wdata);
        end
        cnt = 0;
        foreach (m_busy[i]) cnt += int'(m_busy[i]);
        chk("pending", pend, cnt);
        chk("err", err, m_err);
        if (we === 1'b1) begin
            wlog.push_back(int'(waddr));
            wcyc.push_back(cyc);
        end
        if (!rst_n) begin
            model_reset();
        end else begin
            set_hit = iss_v && (iss_a != 0);
            if (set_hit && m_busy[iss_a] && !(m_we && m_waddr == int'(iss_a))) m_err = 1'b1;
            if (g >= 0 && pa[g] != 0 && !m_busy[pa[g]]) m_err = 1'b1;
            if (m_we) m_busy[m_waddr] = 1'b0;
            if (set_hit) m_busy[iss_a] = 1'b1;
            m_we = (g >= 0) && (pa[g] != 0);
            if (g >= 0) begin
                m_waddr = int'(pa[g]);
                m_wdata = pd[g];
                m_last  = g;
            end
        end
        m_gnt = g;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drop_granted();
        for (int s = 0; s < 3; s++) if (m_gnt == s) pv[s] = 1'b0;
    endtask

    task automatic do_reset(input bit valids);
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            pv[s] = valids; pa[s] = 5'(s + 1); pd[s] = 32'(s);
        end
        iss_v = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) pv[s] = 1'b0;
        wlog.delete();
        wcyc.delete();
    endtask

    initial begin
        rst_n = 1'b0; iss_v = 1'b0; iss_a = '0; rs = '0; rt = '0;
        for (int s = 0; s < 3; s++) begin pv[s] = 1'b1; pa[s] = '0; pd[s] = '0; end
        model_reset();
        m_gnt = -1;

        // reset with every producer requesting
        do_reset(1'b1);
        chk("rst_we", we, 1'b0);
        chk("rst_pend", pend, 0);
        chk("rst_err", err, 1'b0);

        // single ALU write to r5
        rs = 5;
        iss_v = 1'b1; iss_a = 5;
        step();
        iss_v = 1'b0;
        chk("alu_pend1", pend, 1);
        pv[0] = 1'b1; pa[0] = 5; pd[0] = 32'hDEADBEEF;
        step();
        chk("alu_busy_n1", rs_busy, 1'b1);
        pv[0] = 1'b0;
        step();
        chk("alu_busy_n2", rs_busy, 1'b0);
        chk("alu_pend0", pend, 0);
        step();
        chk("alu_wcount", wlog.size(), 1);
        if (wlog.size() == 1) chk("alu_waddr_log", wlog[0], 5);

        // round-robin contention
        do_reset(1'b0);
        for (int r = 1; r <= 3; r++) begin
            iss_v = 1'b1; iss_a = 5'(r);
            step();
        end
        iss_v = 1'b0;
        for (int s = 0; s < 3; s++) begin
            pv[s] = 1'b1; pa[s] = 5'(s + 1); pd[s] = $urandom;
        end
        for (int i = 0; i < 5; i++) begin
            step();
            drop_granted();
        end
        chk("rr_wcount", wlog.size(), 3);
        if (wlog.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("rr_order", wlog[i], i + 1);
                chk("rr_b2b", wcyc[i] - wcyc[0], i);
            end
        end
        chk("rr_err", err, 1'b0);

        // register 0
        do_reset(1'b0);
        iss_v = 1'b1; iss_a = 0;
        pv[0] = 1'b1; pa[0] = 0; pd[0] = 32'h1234;
        step();
        iss_v = 1'b0;
        drop_granted();
        step();
        step();
        chk("r0_no_we", wlog.size(), 0);
        chk("r0_pend", pend, 0);
        chk("r0_err", err, 1'b0);

        // same-edge set and clear of r7
        do_reset(1'b0);
        rs = 7;
        iss_v = 1'b1; iss_a = 7;
        step();
        iss_v = 1'b0;
        pv[0] = 1'b1; pa[0] = 7; pd[0] = $urandom;
        step();
        drop_granted();
        iss_v = 1'b1; iss_a = 7;
        step();
        iss_v = 1'b0;
        step();
        chk("same_busy", rs_busy, 1'b1);
        chk("same_pend", pend, 1);
        chk("same_err", err, 1'b0);

        // double issue, unexpected write, reset after grant
        do_reset(1'b0);
        iss_v = 1'b1; iss_a = 9;
        step();
        step();
        iss_v = 1'b0;
        chk("dbl_err", err, 1'b1);
        pv[1] = 1'b1; pa[1] = 12; pd[1] = $urandom;
        step();
        drop_granted();
        step();
        chk("unexp_written", wlog.size(), 1);
        chk("unexp_err", err, 1'b1);
        wlog.delete();
        pv[1] = 1'b1; pa[1] = 12; pd[1] = $urandom;
        step();
        drop_granted();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("midrst_no_we", wlog.size(), 0);
        chk("midrst_err", err, 1'b0);

        // random traffic
        do_reset(1'b0);
        for (int i = 0; i < 600; i++) begin
            drop_granted();
            for (int s = 0; s < 3; s++) begin
                if (!pv[s] && $urandom_range(0, 1) == 1) begin
                    pv[s] = 1'b1;
                    pa[s] = 5'($urandom_range(0, 7));
                    pd[s] = $urandom;
                end
            end
            iss_v = ($urandom_range(0, 2) == 0);
            iss_a = 5'($urandom_range(0, 7));
            rs    = 5'($urandom_range(0, 7));
            rt    = 5'($urandom_range(0, 7));
            rst_n = ($urandom_range(0, 59) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writer end of the CPU register-file write port.
- Collects results from three producers (ALU, load unit, mul/div unit) with valid/ready handshakes. Grants one per cycle round-robin and drives a registered single write port (o_we/o_waddr/o_wdata) into the register file.
- Keeps a 32-entry pending-write scoreboard so decode can stall on RAW hazards until the write has landed.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (scoreboard depth = 2**ADDR_W)

Ports:
- i_clk  input  1  clock, all state updates on rising edge
- i_rst_n  input  1  synchronous active-low reset
- i_iss_valid  input  1  decode issues an instruction that writes i_iss_waddr
- i_iss_waddr  input  ADDR_W  destination register to mark pending
- i_alu_valid / i_mem_valid / i_mdu_valid  input  1 each  producer result valid
- i_alu_waddr / i_mem_waddr / i_mdu_waddr  input  ADDR_W each  producer destination
- i_alu_wdata / i_mem_wdata / i_mdu_wdata  input  DATA_W each  producer result
- o_alu_ready / o_mem_ready / o_mdu_ready  output  1 each  result accepted this cycle
- i_rs_addr, i_rt_addr  input  ADDR_W  decode source operands
- o_rs_busy, o_rt_busy  output  1  source has a pending write (combinational from scoreboard)
- o_we  output  1  register-file write enable (registered)
- o_waddr  output  ADDR_W  register-file write address (registered)
- o_wdata  output  DATA_W  register-file write data (registered)
- o_pending_cnt  output  ADDR_W+1  number of busy scoreboard entries
- o_err  output  1  sticky protocol-error flag

Behaviour:
- Reset (i_rst_n=0 at edge):
  - o_we, o_waddr, o_wdata, o_err all 0.
  - Scoreboard cleared, o_pending_cnt 0.
  - RR pointer = MDU, so ALU has first priority.
  - Any in-flight registered write is discarded.
- Handshake:
  - Transfer when valid && ready.
  - Producer holds valid, waddr and wdata stable until ready.
  - Exactly one ready high per cycle at most; ready is combinational from valids and RR pointer.
- Arbitration:
  - Fixed cyclic order ALU -> MEM -> MDU.
  - Search starts at the source after the last granted one.
  - Pointer updates only on a grant.
  - A lone requester is granted every cycle, so 1 write/cycle is sustained.
- Latency:
  - Grant in cycle N: o_we=1, o_waddr and o_wdata equal the granted source's values during cycle N+1.
  - Register file captures the write at the end of N+1.
  - o_we lasts exactly one cycle per grant; back-to-back grants give consecutive o_we pulses.
- Register 0:
  - Issue to 0 is ignored; 0 is never busy.
  - Result to 0 is granted (ready=1) but o_we stays 0 in N+1.
  - o_rs_busy / o_rt_busy are 0 for address 0.
- Scoreboard:
  - Set: i_iss_valid with waddr!=0 sets busy[waddr] at the edge.
  - Clear: busy[o_waddr] clears at the end of cycle N+1, the same edge the register file writes. Decode reads the new value from cycle N+2.
  - Simultaneous set and clear of the same register: set wins, busy stays 1, no error.
  - Issue to an already-busy register (not being cleared that edge): o_err set, busy unchanged.
  - Granted result whose waddr!=0 is not busy: write still performed, o_err set.
- o_pending_cnt: popcount of busy, updated with the scoreboard. Max 31.
- o_err: sticky until reset.
- Reset mid-operation: producers see ready=0 while i_rst_n=0. Pending grants are lost; producers re-present after reset.

Test Plan:
- Reset: hold i_rst_n=0 two cycles with all valids=1 -> all readys=0, o_we=0, o_pending_cnt=0, o_err=0.
- Single ALU write:
  - Issue r5; ALU valid r5=0xDEADBEEF next cycle.
  - -> o_rs_busy(r5)=1 until o_we pulse, then 0 the cycle after.
  - -> o_we=1, o_waddr=5, o_wdata=0xDEADBEEF for one cycle, one cycle after grant.
  - -> o_pending_cnt 1 -> 0.
- Round-robin contention:
  - All three valid continuously, to r1/r2/r3, after issuing r1..r3.
  - -> grants ALU, MEM, MDU on consecutive cycles.
  - -> o_waddr sequence 1,2,3 with three back-to-back o_we pulses.
- Register 0: issue r0 and ALU result to r0 = 0x1234 -> o_alu_ready=1, o_we stays 0, o_pending_cnt stays 0, o_err=0.
- Same-edge set and clear:
  - r7 busy; its write retires on the same edge as a new issue to r7.
  - -> busy(r7) remains 1, o_err=0, o_pending_cnt unchanged.
- Errors and mid-op reset:
  - Issue r9 twice without a write -> o_err=1 sticky.
  - Then MEM result to r12 (not busy) -> written, o_err still 1.
  - Reset asserted the cycle after a grant -> no o_we pulse, o_err=0.
